char_cell_scanner: RTL

Parametrised successor to the combinational character-index-to-address mapping in the text overlay path. It accepts a character cell index over a valid/ready handshake and computes the cell's top-left framebuffer address for a configurable text grid. It then streams every pixel address of that cell, row-major, to the glyph blitter, with backpressure. It sits between the text buffer walker (upstream) and the glyph ROM / framebuffer write port (downstream).

---
 rtl/char_cell_scanner.sv | 134 +++++++++++++
 1 files changed

// File: rtl/char_cell_scanner.sv
// Character cell scanner: accepts a text-cell index, then streams that cell's framebuffer pixel addresses row-major.
// Optional feature macro CHAR_SCAN_OOB_CHECK_EN: drop out-of-range indices and pulse err_oob instead of scanning cell 0.
module char_cell_scanner #(
    parameter int SCREEN_WIDTH = 640,
    parameter int ORIGIN_X     = 0,
    parameter int ORIGIN_Y     = 240,
    parameter int CHAR_WIDTH   = 20,
    parameter int CHAR_HEIGHT  = 30,
    parameter int COLS         = 32,
    parameter int ROWS         = 8,
    parameter int ADDR_W       = 19
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           start_valid,
    output logic                           start_ready,
    input  logic [31:0]                    char_index,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [ADDR_W-1:0]              pix_addr,
    output logic [$clog2(CHAR_WIDTH)-1:0]  pix_gx,
    output logic [$clog2(CHAR_HEIGHT)-1:0] pix_gy,
    output logic                           pix_last,
    output logic                           err_oob
);

    localparam int GX_W = $clog2(CHAR_WIDTH);
    localparam int GY_W = $clog2(CHAR_HEIGHT);

    localparam logic [GX_W-1:0]   GX_LAST = GX_W'(CHAR_WIDTH - 1);
    localparam logic [GY_W-1:0]   GY_LAST = GY_W'(CHAR_HEIGHT - 1);
    localparam logic [31:0]       COLS_U  = 32'(COLS);
    localparam logic [31:0]       CELLS_U = 32'(COLS * ROWS);
    localparam logic [ADDR_W-1:0] SW_A    = ADDR_W'(SCREEN_WIDTH);
    localparam logic [ADDR_W-1:0] OX_A    = ADDR_W'(ORIGIN_X);
    localparam logic [ADDR_W-1:0] OY_A    = ADDR_W'(ORIGIN_Y);
    localparam logic [ADDR_W-1:0] CW_A    = ADDR_W'(CHAR_WIDTH);
    localparam logic [ADDR_W-1:0] CH_A    = ADDR_W'(CHAR_HEIGHT);

    typedef enum logic [1:0] {IDLE, CALC, SCAN} state_t;

    state_t            state_q, state_d;
    logic              alive_q;
    logic [ADDR_W-1:0] row_q, col_q, line_base_q;
    logic [GX_W-1:0]   gx_q;
    logic [GY_W-1:0]   gy_q;

    logic              accept, idx_oob, oob_drop, pix_fire;
    logic [ADDR_W-1:0] row_next, col_next, base_calc;

    // Index decode; out-of-range indices fall back to cell 0 when they are scanned at all.
    always_comb begin
        idx_oob  = (char_index >= CELLS_U);
        row_next = idx_oob ? '0 : ADDR_W'(char_index / COLS_U);
        col_next = idx_oob ? '0 : ADDR_W'(char_index % COLS_U);
`ifdef CHAR_SCAN_OOB_CHECK_EN
        oob_drop = idx_oob;
`else
        oob_drop = 1'b0;
`endif
    end

    assign base_calc = (OY_A + row_q * CH_A) * SW_A + OX_A + col_q * CW_A;

    always_comb begin
        state_d     = state_q;
        start_ready = alive_q && (state_q == IDLE);
        pix_valid   = (state_q == SCAN);
        pix_last    = pix_valid && (gx_q == GX_LAST) && (gy_q == GY_LAST);
        accept      = start_valid && start_ready;
        pix_fire    = pix_valid && pix_ready;
        case (state_q)
            IDLE:    if (accept && !oob_drop) state_d = CALC;
            CALC:    state_d = SCAN;
            SCAN:    if (pix_fire && pix_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    // Datapath registers need no reset: every output they feed is gated by the SCAN state.
    always_ff @(posedge clock) begin
        if (accept) begin
            row_q <= row_next;
            col_q <= col_next;
        end
        case (state_q)
            CALC: begin
                line_base_q <= base_calc;
                gx_q        <= '0;
                gy_q        <= '0;
            end
            SCAN: begin
                if (pix_fire) begin
                    if (gx_q != GX_LAST) begin
                        gx_q <= gx_q + 1'b1;
                    end else begin
                        gx_q        <= '0;
                        gy_q        <= gy_q + 1'b1;
                        line_base_q <= line_base_q + SW_A;
                    end
                end
            end
            default: ;
        endcase
    end

    assign pix_addr = pix_valid ? (line_base_q + ADDR_W'(gx_q)) : '0;
    assign pix_gx   = pix_valid ? gx_q : '0;
    assign pix_gy   = pix_valid ? gy_q : '0;

`ifdef CHAR_SCAN_OOB_CHECK_EN
    logic err_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) err_q <= 1'b0;
        else         err_q <= accept && idx_oob;
    end

    assign err_oob = err_q;
`else
    assign err_oob = 1'b0;
`endif

endmodule
